alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle successor of the 32-bit single-cycle ALU in the execute stage of the datapath. It keeps the existing single-cycle operation set, now with a registered result and a start/done handshake. It adds unsigned iterative multiply (shift-add) and unsigned divide (restoring), producing a HI/LO result pair. The execute stage stalls on `ready` while an iterative operation runs.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4 and a power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only when `ready`=1.
- `gin` input 4: operation code, sampled with `start`.
- `a`, `b` input WIDTH: operands, sampled with `start`.
- `ready` output 1: idle, can accept `start`.
- `done` output 1: one-cycle pulse; results valid in this cycle and held until the next `done`.
- `sum` output WIDTH: result. For MULT this is the product low half; for DIVU it is the quotient.
- `hi` output WIDTH: product high half (MULT), remainder (DIVU), 0 otherwise.
- `zout`, `nout`, `overflow` output 1: registered flags for `sum`.
- `dz` output 1: divide by zero, valid with `done`.

## Operation
- Op codes:
  - `0010` ADD, a+b.
  - `0110` SUB, a−b.
  - `0111` SLT, signed a<b gives 1 else 0, computed overflow-correct.
  - `0000` AND.
  - `0001` OR.
  - `0011` PASSA, result a (JALR).
  - `0100` SRLV, b >> a[SHW-1:0], logical.
  - `1000` MULT, unsigned, 2·WIDTH-bit product into {hi,sum}.
  - `1001` DIVU, unsigned; quotient into sum, remainder into hi.
  - Any other code: sum=0, hi=0.
- All arithmetic is modulo 2^WIDTH except the MULT product.
- Flags:
  - `zout` = (sum==0).
  - `nout` = sum[WIDTH-1].
  - `overflow`: ADD gives signed overflow (a,b same sign, sum differs). SUB gives a,b differing sign and sum sign ≠ a sign. MULT gives (hi≠0). All other ops give 0.
  - `dz` = 1 only for DIVU with b==0.
- Divide by zero runs the normal iteration: quotient all ones, remainder = a, `dz`=1.
- State machine:
  - IDLE: `ready`=1. On `start`, single-cycle ops and illegal codes compute and register the result, then go to DONE. MULT and DIVU latch the operands, clear the counter and go to RUN.
  - RUN: `ready`=0. One shift-add or restore step per cycle, counter 0..WIDTH-1. At count WIDTH-1, write the results and go to DONE.
  - DONE: `done`=1 and `ready`=1. `start` is accepted here exactly as in IDLE (back-to-back). With no `start`, go to IDLE.
- `start` with `ready`=0 is ignored; no queueing.
- Reset, including mid-RUN: state IDLE, `ready`=1, `done`=0, sum=hi=0, all flags 0, counter 0. Any in-flight operation is discarded.

## Timing
- `start` sampled at edge k.
- Single-cycle op: `done` and results are visible after edge k+1 (latency 1).
- MULT/DIVU: `done` is visible after edge k+WIDTH+1 (latency WIDTH+1). `ready` is low for WIDTH cycles.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Back-to-back throughput: one single-cycle op per 1 cycle (start held high in DONE); one iterative op per WIDTH+1 cycles.

## Configuration
- `ALU_SEQ_DIV_EN`:
  - Defined: DIVU is implemented as above.
  - Undefined: no divider logic. DIVU is treated as an illegal code (sum=hi=0, `dz`=0, latency 1). MULT is unaffected.

## Structure
- `alu_seq_pkg` holds the op-code localparams (`OP_ADD` … `OP_DIVU`) and the state enum (`S_IDLE`, `S_RUN`, `S_DONE`).
- Sub-module `alu_seq_iter` holds the shared WIDTH-step shift-add/restoring datapath. It covers the partial remainder/product registers, counter, and last-step flag, with divide steps under `ALU_SEQ_DIV_EN`.
- Top level holds the FSM, single-cycle ops, flags and output registers.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+1 → `done` 1 cycle later, sum=0x80000000, overflow=1, nout=1, zout=0.
- SUB 5−5 then SLT −1<1 issued back-to-back in DONE → first gives sum=0, zout=1; next cycle gives sum=1.
- MULT 0xFFFFFFFF×2 → `done` exactly 33 cycles after start, hi=1, sum=0xFFFFFFFE, overflow=1; `start` pulses during RUN are ignored.
- DIVU 100/7 → sum=14, hi=2, dz=0. DIVU 9/0 → sum=0xFFFFFFFF, hi=9, dz=1. With `ALU_SEQ_DIV_EN` undefined, DIVU gives sum=0, latency 1.
- SRLV b=0x80000000, a=35 → shift by 3, sum=0x10000000, nout=0.
- `reset` asserted at RUN cycle 10 of MULT → next cycle ready=1, done=0, sum=hi=0; no `done` pulse follows.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
// Optional divider is controlled by the ALU_SEQ_DIV_EN macro in the users of this package.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_PASSA = 4'b0011;
  localparam logic [3:0] OP_SRLV  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// WIDTH-step shift-add multiplier / restoring divider sharing one register pair.
// Divide steps exist only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
`ifdef ALU_SEQ_DIV_EN
  input  logic             op_div,
`endif
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, op2_q, op2_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;

`ifdef ALU_SEQ_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
`endif

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op2_q} : '0);
    hi_nxt  = mul_sum[WIDTH:1];
    lo_nxt  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    // Trial subtraction is two bits wider so a zero divisor never looks negative.
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, op2_q};
    if (div_q) begin
      if (diff[WIDTH+1]) begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    op2_d = op2_q;
    cnt_d = cnt_q;
`ifdef ALU_SEQ_DIV_EN
    div_d = div_q;
`endif
    if (load) begin
      hi_d  = '0;
      lo_d  = a;
      op2_d = b;
      cnt_d = '0;
`ifdef ALU_SEQ_DIV_EN
      div_d = op_div;
`endif
    end else if (run) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      cnt_d = cnt_q + SHW'(1);
    end
  end

  assign last = (cnt_q == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      op2_q <= '0;
      cnt_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      op2_q <= op2_d;
      cnt_q <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
      div_q <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle ops plus iterative MULT/DIVU with a start/done handshake.
// Define ALU_SEQ_DIV_EN to build the DIVU divider; otherwise DIVU behaves as an illegal code.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] hi,
  output logic             zout,
  output logic             nout,
  output logic             overflow,
  output logic             dz,
  output state_t           dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, hi_q, hi_d;
  logic             zout_q, zout_d, nout_q, nout_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [WIDTH-1:0] add_r, sub_r, sc_sum, it_lo, it_hi;
  logic             add_ovf, sub_ovf, sc_ovf;
  logic             is_div_op, is_iter_op, accept;
  logic             iter_load, iter_run, iter_last, run_div, run_dz;

`ifdef ALU_SEQ_DIV_EN
  logic div_q, div_d, dzp_q, dzp_d;
  assign is_div_op = (gin == OP_DIVU);
  assign run_div   = div_q;
  assign run_dz    = dzp_q;
`else
  assign is_div_op = 1'b0;
  assign run_div   = 1'b0;
  assign run_dz    = 1'b0;
`endif

  always_comb begin
    add_r   = a + b;
    sub_r   = a - b;
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
    sc_sum  = '0;
    sc_ovf  = 1'b0;
    case (gin)
      OP_ADD:   begin sc_sum = add_r; sc_ovf = add_ovf; end
      OP_SUB:   begin sc_sum = sub_r; sc_ovf = sub_ovf; end
      OP_SLT:   sc_sum = {{(WIDTH-1){1'b0}}, sub_r[WIDTH-1] ^ sub_ovf};
      OP_AND:   sc_sum = a & b;
      OP_OR:    sc_sum = a | b;
      OP_PASSA: sc_sum = a;
      OP_SRLV:  sc_sum = b >> a[SHW-1:0];
      default:  sc_sum = '0;
    endcase
  end

  // Handshake: start/gin/a/b are taken on a rising edge where start=1 and ready=1
  // (IDLE or DONE); start while ready=0 is dropped. done is a one-cycle pulse and
  // sum/hi/flags stay valid from that cycle until the next done.
  assign is_iter_op = (gin == OP_MULT) || is_div_op;
  assign accept     = start && (state_q != S_RUN);
  assign iter_run   = (state_q == S_RUN);

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    hi_d      = hi_q;
    zout_d    = zout_q;
    nout_d    = nout_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    iter_load = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    div_d     = div_q;
    dzp_d     = dzp_q;
`endif
    if (state_q == S_RUN) begin
      if (iter_last) begin
        sum_d   = it_lo;
        hi_d    = it_hi;
        zout_d  = (it_lo == '0);
        nout_d  = it_lo[WIDTH-1];
        ovf_d   = !run_div && (it_hi != '0);
        dz_d    = run_dz;
        state_d = S_DONE;
      end
    end else if (accept) begin
      if (is_iter_op) begin
        iter_load = 1'b1;
        state_d   = S_RUN;
`ifdef ALU_SEQ_DIV_EN
        div_d     = is_div_op;
        dzp_d     = is_div_op && (b == '0);
`endif
      end else begin
        sum_d   = sc_sum;
        hi_d    = '0;
        zout_d  = (sc_sum == '0);
        nout_d  = sc_sum[WIDTH-1];
        ovf_d   = sc_ovf;
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      hi_q    <= '0;
      zout_q  <= 1'b0;
      nout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q   <= 1'b0;
      dzp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      zout_q  <= zout_d;
      nout_q  <= nout_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
`ifdef ALU_SEQ_DIV_EN
      div_q   <= div_d;
      dzp_q   <= dzp_d;
`endif
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (iter_load),
`ifdef ALU_SEQ_DIV_EN
    .op_div (is_div_op),
`endif
    .run    (iter_run),
    .a      (a),
    .b      (b),
    .last   (iter_last),
    .lo_nxt (it_lo),
    .hi_nxt (it_hi)
  );

  assign ready     = (state_q != S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign hi        = hi_q;
  assign zout      = zout_q;
  assign nout      = nout_q;
  assign overflow  = ovf_q;
  assign dz        = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32) against an arithmetic reference model.
// Honours ALU_SEQ_DIV_EN the same way as the design.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   gin;
  logic [W-1:0] a, b, sum, hi;
  logic         ready, done, zout, nout, overflow, dz;
  state_t       dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] hi;
    logic         z, n, v, dz;
    int           lat;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .gin(gin), .a(a), .b(b),
    .ready(ready), .done(done), .sum(sum), .hi(hi), .zout(zout), .nout(nout),
    .overflow(overflow), .dz(dz), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // reference model built from the operation rules with plain integer arithmetic
  function automatic exp_t ref_model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.sum = '0; e.hi = '0; e.v = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      OP_ADD:   begin r = sx + sy; e.sum = x + y; e.v = (r > SMAX) || (r < SMIN); end
      OP_SUB:   begin r = sx - sy; e.sum = x - y; e.v = (r > SMAX) || (r < SMIN); end
      OP_SLT:   e.sum = (sx < sy) ? 1 : 0;
      OP_AND:   e.sum = x & y;
      OP_OR:    e.sum = x | y;
      OP_PASSA: e.sum = x;
      OP_SRLV:  e.sum = y >> (x % W);
      OP_MULT: begin
        p = 64'(x) * 64'(y);
        e.sum = p[W-1:0]; e.hi = p[2*W-1:W]; e.v = (e.hi != 0); e.lat = W + 1;
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU: begin
        e.lat = W + 1;
        if (y == 0) begin e.sum = '1; e.hi = x; e.dz = 1'b1; end
        else begin e.sum = x / y; e.hi = x % y; end
      end
`endif
      default: ;
    endcase
    e.z = (e.sum == 0);
    e.n = e.sum[W-1];
    return e;
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // driver: issue one op now (just after an edge) and wait for its done pulse
  task automatic drive_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke, output int lat, output logic [W-1:0] s,
                          output logic [W-1:0] h, output logic [3:0] f, output bit rdy_ok);
    start = 1'b1; gin = op; a = x; b = y;
    lat = 0; rdy_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (done !== 1'b1) begin
        if (ready !== 1'b0) rdy_ok = 1'b0;
        if (poke && lat < W - 2) begin
          start = 1'($urandom_range(0, 1)); gin = OP_ADD; a = $urandom; b = $urandom;
        end
      end
    end while (done !== 1'b1 && lat < W + 8);
    s = sum; h = hi; f = {zout, nout, overflow, dz};
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; gin = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, done, sum, hi, zout, nout, overflow, dz} !== {1'b1, 1'b0, {(2*W){1'b0}}, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b done=%b sum=%h hi=%h f=%b, want rdy=1 done=0 sum=0 hi=0 f=0000",
               ready, done, sum, hi, {zout, nout, overflow, dz});
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_ovf();
    int lat; logic [W-1:0] s, h; logic [3:0] f; bit rok;
    drive_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, s, h, f, rok);
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_cmp++;
    if (s !== 32'h8000_0000) begin n_fail++; $display("FAIL add_sum: got %h want 80000000", s); end
    n_cmp++;
    if (f !== 4'b0110) begin n_fail++; $display("FAIL add_flags(z,n,v,dz): got %b want 0110", f); end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || sum !== 32'h8000_0000) begin
      n_fail++; $display("FAIL add_done_pulse: got done=%b sum=%h want done=0 sum=80000000", done, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[6];
    logic [W-1:0] xs[6], ys[6], want;
    exp_t e;
    ops[0] = OP_SUB; xs[0] = 5;  ys[0] = 5;
    ops[1] = OP_SLT; xs[1] = '1; ys[1] = 1;
    for (int i = 2; i < 6; i++) begin
      ops[i] = 4'($urandom_range(0, 7)); xs[i] = pick_val(); ys[i] = pick_val();
    end
    for (int i = 0; i < 6; i++) begin
      e = ref_model(ops[i], xs[i], ys[i]);
      exp_q.push_back(e.sum);
      start = 1'b1; gin = ops[i]; a = xs[i]; b = ys[i];
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_cmp++;
      if (done !== 1'b1 || sum !== want || zout !== e.z) begin
        n_fail++;
        $display("FAIL b2b_op%0d: got done=%b sum=%h z=%b want done=1 sum=%h z=%b", i, done, sum, zout, want, e.z);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int lat; logic [W-1:0] s, h; logic [3:0] f; bit rok;
    drive_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b1, lat, s, h, f, rok);
    n_cmp++;
    if (lat !== W + 1) begin n_fail++; $display("FAIL mult_latency: got %0d want %0d", lat, W + 1); end
    n_cmp++;
    if ({h, s} !== {32'h1, 32'hFFFF_FFFE}) begin
      n_fail++; $display("FAIL mult_result: got hi=%h sum=%h want hi=00000001 sum=fffffffe", h, s);
    end
    n_cmp++;
    if (f !== 4'b0110) begin n_fail++; $display("FAIL mult_flags(z,n,v,dz): got %b want 0110", f); end
    n_cmp++;
    if (rok !== 1'b1) begin n_fail++; $display("FAIL mult_ready_low: got ready high during run, want low"); end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || hi !== 32'h1 || sum !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mult_hold: got done=%b hi=%h sum=%h want done=0 held result", done, hi, sum);
    end
  endtask

  task automatic test_divu();
    int lat; logic [W-1:0] s, h; logic [3:0] f; bit rok;
    logic [W-1:0] xs[2], ys[2];
    exp_t e;
    xs[0] = 100; ys[0] = 7;
    xs[1] = 9;   ys[1] = 0;
    for (int i = 0; i < 2; i++) begin
      e = ref_model(OP_DIVU, xs[i], ys[i]);
      drive_op(OP_DIVU, xs[i], ys[i], 1'b0, lat, s, h, f, rok);
      n_cmp++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL divu%0d_latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if ({s, h, f} !== {e.sum, e.hi, e.z, e.n, e.v, e.dz}) begin
        n_fail++;
        $display("FAIL divu%0d_result: got sum=%h hi=%h f=%b want sum=%h hi=%h f=%b",
                 i, s, h, f, e.sum, e.hi, {e.z, e.n, e.v, e.dz});
      end
    end
  endtask

  task automatic test_srlv();
    int lat; logic [W-1:0] s, h; logic [3:0] f; bit rok;
    drive_op(OP_SRLV, 32'd35, 32'h8000_0000, 1'b0, lat, s, h, f, rok);
    n_cmp++;
    if (s !== 32'h1000_0000 || f[2] !== 1'b0) begin
      n_fail++; $display("FAIL srlv: got sum=%h n=%b want sum=10000000 n=0", s, f[2]);
    end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] s, h, x, y; logic [3:0] f, op; bit rok;
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15)); x = pick_val(); y = pick_val();
      e = ref_model(op, x, y);
      drive_op(op, x, y, 1'($urandom_range(0, 1)), lat, s, h, f, rok);
      n_cmp++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL rand%0d_latency op=%b: got %0d want %0d", i, op, lat, e.lat); end
      n_cmp++;
      if ({s, h, f} !== {e.sum, e.hi, e.z, e.n, e.v, e.dz}) begin
        n_fail++;
        $display("FAIL rand%0d op=%b a=%h b=%h: got sum=%h hi=%h f=%b want sum=%h hi=%h f=%b",
                 i, op, x, y, s, h, f, e.sum, e.hi, {e.z, e.n, e.v, e.dz});
      end
      if (e.lat > 1) begin
        n_cmp++;
        if (rok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_ready_low: got ready high during run, want low", i); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [W-1:0] s, h; logic [3:0] f; bit rok;
    bit saw_done;
    drive_op(OP_ADD, 32'd3, 32'd4, 1'b0, lat, s, h, f, rok);
    start = 1'b1; gin = OP_MULT; a = $urandom; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({ready, done, sum, hi, zout, nout, overflow, dz} !== {1'b1, 1'b0, {(2*W){1'b0}}, 4'b0000}) begin
      n_fail++;
      $display("FAIL midrun_reset: got rdy=%b done=%b sum=%h hi=%h f=%b, want rdy=1 done=0 sum=0 hi=0 f=0000",
               ready, done, sum, hi, {zout, nout, overflow, dz});
    end
    saw_done = 1'b0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrun_no_done: got done pulse after reset, want none"); end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_back_to_back();
    test_mult();
    test_divu();
    test_srlv();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
